// File: rtl/fwd_hazard_if.sv
// ID-stage request / hazard-response bundle between the decode stage and fwd_hazard_ctrl.
interface fwd_hazard_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_uses_rs1;
  logic                  id_uses_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  flush;
  logic                  stall;
  logic [1:0]            fwd_sel1;
  logic [1:0]            fwd_sel2;
  logic [CNT_W-1:0]      stall_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           id_rd, id_reg_write, id_mem_read, flush,
    input  stall, fwd_sel1, fwd_sel2, stall_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           id_rd, id_reg_write, id_mem_read, flush,
    output stall, fwd_sel1, fwd_sel2, stall_count
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// EX-operand forwarding select generator with load-use stall detection and a saturating
// stall-cycle counter. Keeps a private EX/MEM shadow of in-flight destination info.
module fwd_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input logic       clk,
  input logic       rst,
  fwd_hazard_if.slave bus
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // WB producers are covered by regfile write-through, so no WB shadow is kept.
  logic                  ex_valid_q, ex_valid_d;
  logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
  logic                  ex_reg_write_q, ex_reg_write_d;
  logic                  ex_mem_read_q, ex_mem_read_d;
  logic                  mem_valid_q;
  logic [REG_ADDR_W-1:0] mem_rd_q;
  logic                  mem_reg_write_q;
  logic [1:0]            sel1_q, sel1_d;
  logic [1:0]            sel2_q, sel2_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic hit_ex1, hit_ex2, hit_mem1, hit_mem2;
  logic stall;
  logic load_ex;

  function automatic logic producer_match(
    input logic                  v,
    input logic                  rw,
    input logic [REG_ADDR_W-1:0] rd,
    input logic [REG_ADDR_W-1:0] rs
  );
    return v & rw & (rd != '0) & (rd == rs);
  endfunction

  function automatic logic [1:0] pick_sel(
    input logic uses,
    input logic hit_ex,
    input logic hit_mem
  );
    if (!uses)        return SEL_RF;
    else if (hit_ex)  return SEL_MEM;
    else if (hit_mem) return SEL_WB;
    else              return SEL_RF;
  endfunction

  always_comb begin
    hit_ex1  = producer_match(ex_valid_q, ex_reg_write_q, ex_rd_q, bus.id_rs1);
    hit_ex2  = producer_match(ex_valid_q, ex_reg_write_q, ex_rd_q, bus.id_rs2);
    hit_mem1 = producer_match(mem_valid_q, mem_reg_write_q, mem_rd_q, bus.id_rs1);
    hit_mem2 = producer_match(mem_valid_q, mem_reg_write_q, mem_rd_q, bus.id_rs2);

    stall = bus.id_valid & ~bus.flush & ex_mem_read_q &
            ((bus.id_uses_rs1 & hit_ex1) | (bus.id_uses_rs2 & hit_ex2));

    // Flush, stall and empty ID slots all inject a bubble with neutral selects.
    load_ex = bus.id_valid & ~bus.flush & ~stall;

    ex_valid_d     = load_ex;
    ex_rd_d        = load_ex ? bus.id_rd : '0;
    ex_reg_write_d = load_ex & bus.id_reg_write;
    ex_mem_read_d  = load_ex & bus.id_mem_read;
    sel1_d         = load_ex ? pick_sel(bus.id_uses_rs1, hit_ex1, hit_mem1) : SEL_RF;
    sel2_d         = load_ex ? pick_sel(bus.id_uses_rs2, hit_ex2, hit_mem2) : SEL_RF;

    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) cnt_d = cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q      <= 1'b0;
      ex_rd_q         <= '0;
      ex_reg_write_q  <= 1'b0;
      ex_mem_read_q   <= 1'b0;
      mem_valid_q     <= 1'b0;
      mem_rd_q        <= '0;
      mem_reg_write_q <= 1'b0;
      sel1_q          <= SEL_RF;
      sel2_q          <= SEL_RF;
      cnt_q           <= '0;
    end else begin
      ex_valid_q      <= ex_valid_d;
      ex_rd_q         <= ex_rd_d;
      ex_reg_write_q  <= ex_reg_write_d;
      ex_mem_read_q   <= ex_mem_read_d;
      mem_valid_q     <= ex_valid_q;
      mem_rd_q        <= ex_rd_q;
      mem_reg_write_q <= ex_reg_write_q;
      sel1_q          <= sel1_d;
      sel2_q          <= sel2_d;
      cnt_q           <= cnt_d;
    end
  end

  assign bus.stall       = stall;
  assign bus.fwd_sel1    = sel1_q;
  assign bus.fwd_sel2    = sel2_q;
  assign bus.stall_count = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench for fwd_hazard_ctrl: directed hazard scenarios, random traffic and
// counter saturation, checked against an in-flight-instruction reference model.
module tb_fwd_hazard_ctrl;

  // Narrow counter so saturation is reachable in a short run; behaviour is width-independent.
  localparam int CNT_W   = 10;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fwd_hazard_if #(.REG_ADDR_W(5), .CNT_W(CNT_W)) bus ();

  fwd_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #10 clk = ~clk;

  typedef struct {
    bit v;
    int rd;
    bit rw;
    bit mr;
  } slot_t;

  typedef struct {
    bit    stall;
    int    sel1;
    int    sel2;
    int    cnt;
    string tag;
  } exp_t;

  // pipe[age]: age 0 = instruction now in EX, age 1 = instruction now in MEM
  slot_t pipe[2];
  int    model_cnt;
  exp_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;

  function automatic bit produces(slot_t s, int rs);
    return s.v && s.rw && (s.rd != 0) && (s.rd == rs);
  endfunction

  // Forwarding code is (age of youngest in-flight producer) + 1.
  function automatic int want_sel(bit uses, int rs);
    if (!uses || rs == 0) return 0;
    for (int age = 0; age < 2; age++)
      if (produces(pipe[age], rs)) return age + 1;
    return 0;
  endfunction

  function automatic bit want_stall(bit v, bit fl, bit u1, int rs1, bit u2, int rs2);
    return v && !fl && pipe[0].v && pipe[0].mr &&
           ((u1 && produces(pipe[0], rs1)) || (u2 && produces(pipe[0], rs2)));
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) pipe[i] = '{v: 1'b0, rd: 0, rw: 1'b0, mr: 1'b0};
    model_cnt = 0;
  endtask

  // One ID-slot cycle: drive at negedge, predict, optionally pulse reset between edges.
  task automatic issue(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                       input int rd, input bit rw, input bit mr, input bit fl,
                       input bit rst_pulse, input string tag, output bit st);
    exp_t e;
    bit   kill;
    @(negedge clk);
    bus.id_valid     = v;
    bus.id_rs1       = 5'(rs1);
    bus.id_rs2       = 5'(rs2);
    bus.id_uses_rs1  = u1;
    bus.id_uses_rs2  = u2;
    bus.id_rd        = 5'(rd);
    bus.id_reg_write = rw;
    bus.id_mem_read  = mr;
    bus.flush        = fl;

    e.tag   = tag;
    e.stall = want_stall(v, fl, u1, rs1, u2, rs2);
    if (rst_pulse) model_clear();
    st   = rst_pulse ? want_stall(v, fl, u1, rs1, u2, rs2) : e.stall;
    kill = fl || st || !v;
    e.sel1 = kill ? 0 : want_sel(u1, rs1);
    e.sel2 = kill ? 0 : want_sel(u2, rs2);
    if (st && model_cnt < CNT_MAX) model_cnt++;
    e.cnt   = model_cnt;
    pipe[1] = pipe[0];
    pipe[0] = kill ? '{v: 1'b0, rd: 0, rw: 1'b0, mr: 1'b0} : '{v: 1'b1, rd: rd, rw: rw, mr: mr};
    exp_q.push_back(e);

    if (rst_pulse) begin
      #3 rst = 1'b1;
      #1;
      chk("reset-now stall", int'(bus.stall), 0);
      chk("reset-now sel1", int'(bus.fwd_sel1), 0);
      chk("reset-now sel2", int'(bus.fwd_sel2), 0);
      chk("reset-now count", int'(bus.stall_count), 0);
      #1 rst = 1'b0;
    end
  endtask

  // Monitor: stall sampled mid-cycle, registered outputs just after the edge.
  initial begin
    exp_t e;
    bit   s_stall;
    forever begin
      @(negedge clk);
      #2 s_stall = bus.stall;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({e.tag, " stall"}, int'(s_stall), int'(e.stall));
        chk({e.tag, " sel1"}, int'(bus.fwd_sel1), e.sel1);
        chk({e.tag, " sel2"}, int'(bus.fwd_sel2), e.sel2);
        chk({e.tag, " count"}, int'(bus.stall_count), e.cnt);
      end
    end
  end

  initial begin
    bit v, u1, u2, rw, mr, fl, st, hold;
    int rs1, rs2, rd;

    bus.id_valid = 1'b0; bus.id_rs1 = '0; bus.id_rs2 = '0;
    bus.id_uses_rs1 = 1'b0; bus.id_uses_rs2 = 1'b0; bus.id_rd = '0;
    bus.id_reg_write = 1'b0; bus.id_mem_read = 1'b0; bus.flush = 1'b0;
    model_clear();
    #5;
    chk("reset stall", int'(bus.stall), 0);
    chk("reset sel1", int'(bus.fwd_sel1), 0);
    chk("reset sel2", int'(bus.fwd_sel2), 0);
    chk("reset count", int'(bus.stall_count), 0);
    #10 rst = 1'b0;

    // T1: EX->EX dependency
    issue(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, "T1 add x5", st);
    issue(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, "T1 add x6,x5,x1", st);
    // T2: MEM-distance producer, then youngest-wins
    issue(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, "T2 add x5", st);
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "T2 nop", st);
    issue(1, 2, 5, 1, 1, 7, 1, 0, 0, 0, "T2 sub x7,x2,x5", st);
    issue(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, "T2 add x5 a", st);
    issue(1, 5, 0, 1, 0, 5, 1, 0, 0, 0, "T2 add x5 b", st);
    issue(1, 2, 5, 1, 1, 7, 1, 0, 0, 0, "T2 sub x7 youngest", st);
    // T3: load-use
    issue(1, 1, 0, 1, 0, 7, 1, 1, 0, 0, "T3 lw x7", st);
    issue(1, 7, 7, 1, 1, 8, 1, 0, 0, 0, "T3 add stalled", st);
    issue(1, 7, 7, 1, 1, 8, 1, 0, 0, 0, "T3 add released", st);
    // T4: x0 is never a producer
    issue(1, 1, 0, 1, 0, 0, 1, 0, 0, 0, "T4 addi x0", st);
    issue(1, 0, 0, 1, 1, 9, 1, 0, 0, 0, "T4 add x9,x0,x0 a", st);
    issue(1, 1, 0, 1, 0, 0, 1, 1, 0, 0, "T4 lw x0", st);
    issue(1, 0, 0, 1, 1, 9, 1, 0, 0, 0, "T4 add x9,x0,x0 b", st);
    // T5: flush overrides load-use
    issue(1, 1, 0, 1, 0, 7, 1, 1, 0, 0, "T5 lw x7", st);
    issue(1, 7, 7, 1, 1, 8, 1, 0, 1, 0, "T5 dep flushed", st);
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "T5 nop", st);

    // Random traffic; a stalled ID instruction is held for the next cycle.
    hold = 1'b0;
    for (int i = 0; i < 400; i++) begin
      fl = ($urandom_range(9) == 0);
      if (!hold) begin
        v   = ($urandom_range(7) != 0);
        rs1 = $urandom_range(3); rs2 = $urandom_range(3); rd = $urandom_range(3);
        u1  = $urandom_range(1); u2 = $urandom_range(1);
        rw  = ($urandom_range(3) != 0);
        mr  = ($urandom_range(2) == 0);
      end
      issue(v, rs1, rs2, u1, u2, rd, rw, mr, fl, 0, "RND", st);
      hold = st;
    end

    // Counter saturation: self-dependent loads stall every other cycle.
    for (int i = 0; i < 2 * (CNT_MAX + 1) + 20; i++)
      issue(1, 7, 0, 1, 0, 7, 1, 1, 0, 0, "SAT lw x7,x7", st);
    // T6: reset mid-stream, pre-reset producer must not be forwarded
    issue(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, "T6 add x5", st);
    issue(1, 5, 5, 1, 1, 6, 1, 0, 0, 1, "T6 consumer across reset", st);
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "T6 nop", st);

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
